// File: rtl/mult_div_seq.sv
// mult_div_seq: multicycle signed MULT/DIV sequencer writing the HI/LO registers.
// Magnitudes are latched at start, WIDTH shift-add or restoring-divide steps run
// one per cycle, and a single FIX cycle applies signs and updates hi/lo.
module mult_div_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multControl,
  input  logic             divControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             zeroDiv
);

  localparam int unsigned W2 = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]       state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             is_div, nxt_is_div;
  logic             sgn_q, nxt_sgn_q;
  logic             sgn_r, nxt_sgn_r;
  logic [W2-1:0]    acc, nxt_acc;     // mult: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0] opb, nxt_opb;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] nxt_hi, nxt_lo;
  logic             nxt_busy, nxt_done, nxt_zero;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  assign mag_a = a[WIDTH-1] ? WIDTH'(0) - a : a;
  assign mag_b = b[WIDTH-1] ? WIDTH'(0) - b : b;

  // Per-step datapath terms.
  assign mul_sum   = {1'b0, acc[W2-1:WIDTH]} + {1'b0, opb};
  assign div_shift = {acc[W2-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};

  // Sign fix-up applied in the FIX cycle.
  assign prod_fix = sgn_q ? W2'(0) - acc : acc;
  assign q_fix    = sgn_q ? WIDTH'(0) - acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix    = sgn_r ? WIDTH'(0) - acc[W2-1:WIDTH] : acc[W2-1:WIDTH];

  // State, datapath and output register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      sgn_q   <= 1'b0;
      sgn_r   <= 1'b0;
      acc     <= '0;
      opb     <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      zeroDiv <= 1'b0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      is_div  <= nxt_is_div;
      sgn_q   <= nxt_sgn_q;
      sgn_r   <= nxt_sgn_r;
      acc     <= nxt_acc;
      opb     <= nxt_opb;
      hi      <= nxt_hi;
      lo      <= nxt_lo;
      busy    <= nxt_busy;
      done    <= nxt_done;
      zeroDiv <= nxt_zero;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_is_div = is_div;
    nxt_sgn_q  = sgn_q;
    nxt_sgn_r  = sgn_r;
    nxt_acc    = acc;
    nxt_opb    = opb;
    nxt_hi     = hi;
    nxt_lo     = lo;
    nxt_busy   = busy;
    nxt_done   = 1'b0;
    nxt_zero   = 1'b0;

    case (state)
      S_IDLE: begin
        if (multControl) begin
          nxt_acc    = {WIDTH'(0), mag_b};
          nxt_opb    = mag_a;
          nxt_sgn_q  = a[WIDTH-1] ^ b[WIDTH-1];
          nxt_is_div = 1'b0;
          nxt_cnt    = '0;
          nxt_busy   = 1'b1;
          nxt_state  = S_MULT;
        end else if (divControl) begin
          if (b == '0) begin
            nxt_zero = 1'b1;
          end else begin
            nxt_acc    = {WIDTH'(0), mag_a};
            nxt_opb    = mag_b;
            nxt_sgn_q  = a[WIDTH-1] ^ b[WIDTH-1];
            nxt_sgn_r  = a[WIDTH-1];
            nxt_is_div = 1'b1;
            nxt_cnt    = '0;
            nxt_busy   = 1'b1;
            nxt_state  = S_DIV;
          end
        end
      end
      S_MULT: begin
        if (acc[0]) nxt_acc = {mul_sum, acc[WIDTH-1:1]};
        else        nxt_acc = {1'b0, acc[W2-1:1]};
        nxt_cnt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) nxt_state = S_FIX;
      end
      S_DIV: begin
        if (!div_diff[WIDTH]) nxt_acc = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else                  nxt_acc = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        nxt_cnt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) nxt_state = S_FIX;
      end
      S_FIX: begin
        if (is_div) begin
          nxt_lo = q_fix;
          nxt_hi = r_fix;
        end else begin
          nxt_hi = prod_fix[W2-1:WIDTH];
          nxt_lo = prod_fix[WIDTH-1:0];
        end
        nxt_done  = 1'b1;
        nxt_busy  = 1'b0;
        nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: scoreboard bench for mult_div_seq; expected {hi,lo} queued at issue,
// popped and compared by a monitor on every done pulse.
module tb_mult_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        multControl, divControl;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done, zeroDiv;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];

  mult_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .multControl(multControl), .divControl(divControl),
    .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .zeroDiv(zeroDiv)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got hi=%h lo=%h, expected no done", hi, lo);
      end else begin
        check("hilo", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  // Issue one operation, then watch busy/done until completion.
  task automatic run_op(input logic m, input logic d, input logic [31:0] av,
                        input logic [31:0] bv, input logic [63:0] e, input string name);
    int bc;
    logic got;
    exp_q.push_back(e);
    @(negedge clk);
    multControl = m; divControl = d; a = av; b = bv;
    @(posedge clk);
    #1 multControl = 1'b0; divControl = 1'b0;
    bc = 0; got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) got = 1'b1;
    end
    check({name, "_done"}, 64'(got), 64'd1);
    check({name, "_busy_cycles"}, 64'(bc), 64'd33);
    @(negedge clk);
    check({name, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int zc, bc, dc;
    reset = 1'b1; multControl = 1'b0; divControl = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_flags", {61'd0, busy, done, zeroDiv}, 64'd0);

    run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, {32'hFFFFFFFF, 32'hFFFFFFEB}, "mul_7_m3");
    run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, "div_m7_2");
    run_op(1'b0, 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, "div_7_m2");
    run_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, {32'h40000000, 32'h00000000}, "mul_min_min");
    run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, "div_min_m1");
    // 0x2AAAAAAB * 0x66 = 0x11_00000022
    run_op(1'b1, 1'b0, 32'h2AAAAAAB, 32'h00000066, {32'h00000011, 32'h00000022}, "mul_set_hilo");

    // Divide by zero: one-cycle zeroDiv, no busy, hi/lo untouched.
    @(negedge clk);
    divControl = 1'b1; a = 32'd5; b = 32'd0;
    @(posedge clk);
    #1 divControl = 1'b0;
    zc = 0; bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (zeroDiv) zc++;
      if (busy) bc++;
    end
    check("div0_zero_cycles", 64'(zc), 64'd1);
    check("div0_busy_cycles", 64'(bc), 64'd0);
    check("div0_hilo", {hi, lo}, {32'h00000011, 32'h00000022});

    // Abort: divControl mid-multiply is ignored, reset at iteration 10 clears everything.
    @(negedge clk);
    multControl = 1'b1; a = 32'd100; b = 32'd200;
    @(posedge clk);
    #1 multControl = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    divControl = 1'b1; a = 32'd5; b = 32'd6;
    @(posedge clk);
    #1 divControl = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_flags", {62'd0, busy, done}, 64'd0);
    bc = 0; dc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) dc++;
    end
    check("abort_quiet", {32'(bc), 32'(dc)}, 64'd0);
    run_op(1'b1, 1'b0, 32'd3, 32'd4, {32'd0, 32'd12}, "mul_3_4");

    // Both strobes: multiply wins.
    run_op(1'b1, 1'b1, 32'd5, 32'd6, {32'd0, 32'd30}, "both_5_6");

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
